// File: rtl/clarvi_timer_pkg.sv
// Shared definitions for the clarvi_timer block. The register offsets, the
// CTRL layout and the mtimecmp reset value all live here. Both the top level
// and the testbench's view of the map depend on them.
package clarvi_timer_pkg;

  // Word offsets inside the MMIO window. Offsets 6 and 7 are unmapped.
  typedef enum logic [2:0] {
    REG_MTIME_LO    = 3'd0,
    REG_MTIME_HI    = 3'd1,
    REG_MTIMECMP_LO = 3'd2,
    REG_MTIMECMP_HI = 3'd3,
    REG_CTRL        = 3'd4,
    REG_STATUS      = 3'd5
  } timer_reg_e;

  // CTRL register: bit1 = IE, bit0 = EN.
  typedef struct packed {
    logic ie;
    logic en;
  } timer_ctrl_t;

  localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

  // Merge a 32-bit write into an existing word, one byte lane at a time.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/clarvi_timer_prescaler.sv
// Prescaler for the mtime counter.
// Ports:
//   clock - system clock (posedge)
//   reset - synchronous, active-low reset
//   en    - count enable (CTRL.EN)
//   clear - forces the count back to 0 (software wrote mtime this cycle)
//   tick  - one-cycle pulse: mtime should advance this cycle
module timer_prescaler #(
  parameter int PRESCALE       = 1,
  parameter int PRESCALE_WIDTH = $clog2(PRESCALE + 1)
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  input  logic clear,
  output logic tick
);

  localparam logic [PRESCALE_WIDTH-1:0] TERMINAL = PRESCALE_WIDTH'(PRESCALE - 1);

  logic [PRESCALE_WIDTH-1:0] r_count;

  // No tick while clearing: a software write to mtime wins over the increment.
  assign tick = en && !clear && (r_count == TERMINAL);

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= tick ? '0 : r_count + PRESCALE_WIDTH'(1);
    end
  end

endmodule

// File: rtl/clarvi_timer.sv
// RISC-V style machine timer as an Avalon-MM slave: 64-bit mtime, 64-bit
// mtimecmp, CTRL (EN/IE) and a sticky STATUS.MATCH bit. Drives a level timer
// interrupt.
// Ports:
//   clock, reset              - system clock, synchronous active-low reset
//   avs_address/byteenable    - word offset and byte-lane mask
//   avs_read/avs_write        - request strobes, writedata for writes
//   avs_readdata/readdatavalid- registered read response, 1 cycle after read
//   avs_waitrequest           - always 0
//   irq                       - registered IE & (mtime >= mtimecmp)
// Handshake: a request is accepted in any cycle where avs_read or avs_write is
// high (waitrequest is never asserted). avs_readdatavalid pulses exactly one
// cycle after each accepted read, and avs_readdata holds between reads.
module clarvi_timer
  import clarvi_timer_pkg::*;
#(
  parameter int ADDR_WIDTH     = 3,
  parameter int PRESCALE       = 1,
  parameter int PRESCALE_WIDTH = $clog2(PRESCALE + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] avs_address,
  input  logic [3:0]            avs_byteenable,
  input  logic                  avs_read,
  output logic [31:0]           avs_readdata,
  output logic                  avs_readdatavalid,
  input  logic                  avs_write,
  input  logic [31:0]           avs_writedata,
  output logic                  avs_waitrequest,
  output logic                  irq
);

  logic [63:0] r_mtime;
  logic [63:0] r_mtimecmp;
  timer_ctrl_t r_ctrl;
  logic        r_match;
  logic        r_irq;
  logic [31:0] r_hi_shadow;
  logic [31:0] r_rdata;
  logic        r_rdvalid;

  timer_reg_e  w_addr;
  logic        w_wr_lo;
  logic        w_wr_hi;
  logic        w_tick;
  logic        w_match_now;
  logic        w_status_clr;
  logic [31:0] w_rd_mux;

  assign w_addr       = timer_reg_e'(avs_address[2:0]);
  assign w_wr_lo      = avs_write && (w_addr == REG_MTIME_LO);
  assign w_wr_hi      = avs_write && (w_addr == REG_MTIME_HI);
  assign w_match_now  = (r_mtime >= r_mtimecmp);
  assign w_status_clr = avs_write && (w_addr == REG_STATUS) &&
                        avs_byteenable[0] && avs_writedata[0];

  assign avs_waitrequest   = 1'b0;
  assign avs_readdata      = r_rdata;
  assign avs_readdatavalid = r_rdvalid;
  assign irq               = r_irq;

  timer_prescaler #(
    .PRESCALE       (PRESCALE),
    .PRESCALE_WIDTH (PRESCALE_WIDTH)
  ) u_prescaler (
    .clock (clock),
    .reset (reset),
    .en    (r_ctrl.en),
    .clear (w_wr_lo || w_wr_hi),
    .tick  (w_tick)
  );

  // Read mux sees only registered state, so a same-cycle write to the same
  // offset is not visible in this read.
  always_comb begin
    w_rd_mux = '0;
    case (w_addr)
      REG_MTIME_LO:    w_rd_mux = r_mtime[31:0];
      REG_MTIME_HI:    w_rd_mux = r_hi_shadow;
      REG_MTIMECMP_LO: w_rd_mux = r_mtimecmp[31:0];
      REG_MTIMECMP_HI: w_rd_mux = r_mtimecmp[63:32];
      REG_CTRL:        w_rd_mux = {30'd0, r_ctrl.ie, r_ctrl.en};
      REG_STATUS:      w_rd_mux = {31'd0, r_match};
      default:         w_rd_mux = '0;
    endcase
  end

  // mtime: a write to either half freezes the other half for that cycle
  // (no increment, no carry), so software sees exactly what it wrote.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_mtime <= '0;
    end else if (w_wr_lo) begin
      r_mtime[31:0] <= byte_merge(r_mtime[31:0], avs_writedata, avs_byteenable);
    end else if (w_wr_hi) begin
      r_mtime[63:32] <= byte_merge(r_mtime[63:32], avs_writedata, avs_byteenable);
    end else if (w_tick) begin
      r_mtime <= r_mtime + 64'd1;
    end
  end

  // mtimecmp, CTRL, STATUS and irq.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_mtimecmp <= MTIMECMP_RESET;
      r_ctrl     <= '0;
      r_match    <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      if (avs_write && (w_addr == REG_MTIMECMP_LO))
        r_mtimecmp[31:0] <= byte_merge(r_mtimecmp[31:0], avs_writedata, avs_byteenable);
      if (avs_write && (w_addr == REG_MTIMECMP_HI))
        r_mtimecmp[63:32] <= byte_merge(r_mtimecmp[63:32], avs_writedata, avs_byteenable);
      if (avs_write && (w_addr == REG_CTRL) && avs_byteenable[0])
        r_ctrl <= timer_ctrl_t'(avs_writedata[1:0]);
      // Set beats a simultaneous write-1-to-clear.
      r_match <= w_match_now || (r_match && !w_status_clr);
      r_irq   <= r_ctrl.ie && w_match_now;
    end
  end

  // Read pipeline. Reading MTIME_LO snapshots the high word so a following
  // MTIME_HI read is coherent even if a carry happened in between.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_rdata     <= '0;
      r_rdvalid   <= 1'b0;
      r_hi_shadow <= '0;
    end else begin
      r_rdvalid <= avs_read;
      if (avs_read) begin
        r_rdata <= w_rd_mux;
        if (w_addr == REG_MTIME_LO) r_hi_shadow <= r_mtime[63:32];
      end
    end
  end

endmodule

// File: tb/tb_clarvi_timer.sv
// Testbench for clarvi_timer. Two instances (PRESCALE=1 and PRESCALE=4) share
// one Avalon stimulus stream; a register-level reference model predicts every
// cycle's outputs and the read data of each accepted read.
module tb_clarvi_timer;

  logic        clock;
  logic        reset;
  logic [2:0]  avs_address;
  logic [3:0]  avs_byteenable;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;

  logic [31:0] rdata0, rdata1;
  logic        rdv0, rdv1, wait0, wait1, irq0, irq1;

  clarvi_timer #(.ADDR_WIDTH(3), .PRESCALE(1)) u_dut_p1 (
    .clock(clock), .reset(reset), .avs_address(avs_address),
    .avs_byteenable(avs_byteenable), .avs_read(avs_read),
    .avs_readdata(rdata0), .avs_readdatavalid(rdv0), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_waitrequest(wait0), .irq(irq0)
  );

  clarvi_timer #(.ADDR_WIDTH(3), .PRESCALE(4)) u_dut_p4 (
    .clock(clock), .reset(reset), .avs_address(avs_address),
    .avs_byteenable(avs_byteenable), .avs_read(avs_read),
    .avs_readdata(rdata1), .avs_readdatavalid(rdv1), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_waitrequest(wait1), .irq(irq1)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic [1:0]       valid;
    logic [1:0]       irq;
    logic [1:0][31:0] rd;
  } cyc_exp_t;

  cyc_exp_t    ctl_q[$];
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  int          checks = 0;
  int          errors = 0;
  logic        started = 1'b0;

  // ---------------- reference model ----------------
  int          presc[2] = '{1, 4};
  logic [63:0] m_time[2];
  logic [63:0] m_cmp[2];
  logic        m_en[2], m_ie[2], m_match[2], m_irq[2];
  int          m_pre[2];
  logic [31:0] m_shadow[2], m_rdata[2];

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  // Advance the model by one clock edge given the inputs presented before it.
  task automatic model_step(input logic rst_n, input logic rd, input logic wr,
                            input logic [2:0] addr, input logic [3:0] be,
                            input logic [31:0] wd);
    cyc_exp_t e;
    logic hit, clr, n_irq, n_match;
    logic [31:0] rv;
    e = '0;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_time[k] = 64'd0;      m_cmp[k] = {64{1'b1}};
        m_en[k] = 1'b0;         m_ie[k] = 1'b0;
        m_match[k] = 1'b0;      m_irq[k] = 1'b0;
        m_pre[k] = 0;           m_shadow[k] = 32'd0;
        m_rdata[k] = 32'd0;     e.valid[k] = 1'b0;
      end else begin
        hit = (m_time[k] >= m_cmp[k]);
        clr = wr && (addr == 3'd5) && be[0] && wd[0];
        e.valid[k] = rd;
        if (rd) begin
          case (addr)
            3'd0:    rv = m_time[k][31:0];
            3'd1:    rv = m_shadow[k];
            3'd2:    rv = m_cmp[k][31:0];
            3'd3:    rv = m_cmp[k][63:32];
            3'd4:    rv = {30'd0, m_ie[k], m_en[k]};
            3'd5:    rv = {31'd0, m_match[k]};
            default: rv = 32'd0;
          endcase
          m_rdata[k] = rv;
          if (k == 0) exp_q0.push_back(rv); else exp_q1.push_back(rv);
          if (addr == 3'd0) m_shadow[k] = m_time[k][63:32];
        end
        n_irq   = m_ie[k] && hit;
        n_match = hit || (m_match[k] && !clr);
        if (wr && addr == 3'd0) begin
          m_time[k][31:0] = merge(m_time[k][31:0], wd, be);
          m_pre[k] = 0;
        end else if (wr && addr == 3'd1) begin
          m_time[k][63:32] = merge(m_time[k][63:32], wd, be);
          m_pre[k] = 0;
        end else if (m_en[k]) begin
          m_pre[k] = m_pre[k] + 1;
          if (m_pre[k] == presc[k]) begin
            m_pre[k] = 0;
            m_time[k] = m_time[k] + 64'd1;
          end
        end
        if (wr && addr == 3'd2) m_cmp[k][31:0]  = merge(m_cmp[k][31:0], wd, be);
        if (wr && addr == 3'd3) m_cmp[k][63:32] = merge(m_cmp[k][63:32], wd, be);
        if (wr && addr == 3'd4 && be[0]) begin
          m_en[k] = wd[0];
          m_ie[k] = wd[1];
        end
        m_irq[k]   = n_irq;
        m_match[k] = n_match;
      end
      e.irq[k] = m_irq[k];
      e.rd[k]  = m_rdata[k];
    end
    ctl_q.push_back(e);
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc(input logic rst_n, input logic rd, input logic wr,
                     input logic [2:0] addr, input logic [3:0] be,
                     input logic [31:0] wd);
    @(negedge clock);
    reset = rst_n; avs_read = rd; avs_write = wr;
    avs_address = addr; avs_byteenable = be; avs_writedata = wd;
    model_step(rst_n, rd, wr, addr, be, wd);
    started = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 3'd0, 4'h0, 32'd0);
  endtask

  task automatic wr_reg(input logic [2:0] addr, input logic [31:0] wd);
    cyc(1'b1, 1'b0, 1'b1, addr, 4'hF, wd);
  endtask

  task automatic rd_reg(input logic [2:0] addr);
    cyc(1'b1, 1'b1, 1'b0, addr, 4'h0, 32'd0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 3'd0, 4'h0, 32'd0);
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic mon_one(input int k, input logic v, input logic irq_a,
                         input logic [31:0] rd_a, input logic wt_a, input cyc_exp_t e);
    logic [31:0] x;
    chk($sformatf("dut%0d_readdatavalid", k), 64'(v), 64'(e.valid[k]));
    chk($sformatf("dut%0d_irq", k), 64'(irq_a), 64'(e.irq[k]));
    chk($sformatf("dut%0d_readdata_hold", k), 64'(rd_a), 64'(e.rd[k]));
    chk($sformatf("dut%0d_waitrequest", k), 64'(wt_a), 64'd0);
    if (v) begin
      if ((k == 0 && exp_q0.size() == 0) || (k == 1 && exp_q1.size() == 0)) begin
        checks++; errors++;
        $display("FAIL dut%0d_unexpected_read: got %h expected no response", k, rd_a);
      end else begin
        x = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        chk($sformatf("dut%0d_read_data", k), 64'(rd_a), 64'(x));
      end
    end
  endtask

  // Monitor: one expected entry per clock edge, compared mid-cycle.
  initial begin
    cyc_exp_t e;
    wait (started);
    forever begin
      @(negedge clock);
      if (ctl_q.size() > 0) begin
        e = ctl_q.pop_front();
        mon_one(0, rdv0, irq0, rdata0, wait0, e);
        mon_one(1, rdv1, irq1, rdata1, wait1, e);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0; avs_read = 1'b0; avs_write = 1'b0;
    avs_address = 3'd0; avs_byteenable = 4'h0; avs_writedata = 32'd0;

    // Reset state and a sweep of the whole window.
    do_reset(2);
    for (int a = 0; a < 8; a++) rd_reg(3'(a));

    // Free-running count, then a LO read.
    wr_reg(3'd4, 32'h1);
    idle(10);
    rd_reg(3'd0);
    idle(2);

    // Carry across the 32-bit boundary; LO-then-HI coherence.
    wr_reg(3'd4, 32'h0);
    wr_reg(3'd0, 32'hFFFF_FFFE);
    wr_reg(3'd1, 32'h0);
    wr_reg(3'd4, 32'h1);
    idle(4);
    rd_reg(3'd0);
    rd_reg(3'd1);
    wr_reg(3'd1, 32'h0);
    wr_reg(3'd0, 32'hFFFF_FFFF);
    rd_reg(3'd0);
    rd_reg(3'd1);
    rd_reg(3'd0);
    rd_reg(3'd1);

    // Compare / irq / sticky MATCH.
    do_reset(1);
    wr_reg(3'd2, 32'd100);
    wr_reg(3'd3, 32'd0);
    wr_reg(3'd4, 32'h3);
    idle(100);
    rd_reg(3'd5);
    wr_reg(3'd2, 32'd200);
    idle(3);
    rd_reg(3'd5);
    cyc(1'b1, 1'b1, 1'b1, 3'd5, 4'hF, 32'h1);   // read + clear together
    rd_reg(3'd5);
    idle(110);
    wr_reg(3'd4, 32'h1);                         // drop IE
    idle(3);
    cyc(1'b1, 1'b0, 1'b1, 3'd5, 4'hF, 32'h1);   // clear while still matching
    rd_reg(3'd5);

    // Enable window, then hold.
    do_reset(1);
    wr_reg(3'd4, 32'h1);
    idle(20);
    wr_reg(3'd4, 32'h0);
    rd_reg(3'd0);
    idle(10);
    rd_reg(3'd0);

    // Byte-lane write from reset.
    do_reset(1);
    cyc(1'b1, 1'b0, 1'b1, 3'd2, 4'b0010, 32'hAABB_CCDD);
    rd_reg(3'd2);
    cyc(1'b1, 1'b0, 1'b1, 3'd0, 4'b1001, 32'h1122_3344);
    rd_reg(3'd0);

    // Reset with irq high and a read in flight.
    do_reset(1);
    wr_reg(3'd2, 32'd5);
    wr_reg(3'd3, 32'd0);
    wr_reg(3'd4, 32'h3);
    idle(30);
    cyc(1'b0, 1'b1, 1'b0, 3'd0, 4'h0, 32'd0);
    rd_reg(3'd0);
    rd_reg(3'd2);
    rd_reg(3'd3);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      logic        r_n, rd, wr;
      logic [2:0]  a;
      logic [3:0]  be;
      logic [31:0] wd;
      r_n = ($urandom_range(0, 99) != 0);
      rd  = ($urandom_range(0, 2) == 0);
      wr  = ($urandom_range(0, 2) == 0);
      a   = 3'($urandom_range(0, 7));
      be  = ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom_range(0, 15));
      wd  = $urandom;
      if (wr && (a == 3'd0 || a == 3'd2) && $urandom_range(0, 1) != 0)
        wd = 32'($urandom_range(0, 400));
      if (wr && (a == 3'd1 || a == 3'd3) && $urandom_range(0, 3) != 0)
        wd = 32'd0;
      if (wr && a == 3'd4) wd[0] = ($urandom_range(0, 3) != 0);
      cyc(r_n, rd, wr, a, be, wd);
    end

    idle(3);
    @(negedge clock);
    @(negedge clock);
    chk("read_queue0_drained", 64'(exp_q0.size()), 64'd0);
    chk("read_queue1_drained", 64'(exp_q1.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clarvi_timer.md
Name: clarvi_timer

Overview:
- Avalon-MM slave that holds a RISC-V-style 64-bit mtime counter and an mtimecmp compare register.
- Drives the core's level-sensitive timer interrupt (inr_irq) directly upstream of clarvi_avalon.
- Sits on the main data bus beside dual_port_bram, decoded at a word-aligned MMIO window.
- Software sets the next deadline through Avalon writes; mtime and status are read back the same way.

Parameters:
- ADDR_WIDTH, 3: word-address width of the register window; only address[2:0] is decoded.
- PRESCALE, 1: clock cycles per mtime increment. Must be ≥1. A value of 1 means mtime increments every enabled cycle.
- PRESCALE_WIDTH, $clog2(PRESCALE+1): width of the prescaler counter.

Ports:
- clock  in  1  single system clock; all logic on posedge.
- reset  in  1  synchronous, active-low reset: state clears on a posedge clock when reset==0.
- avs_address  in  ADDR_WIDTH  word address of the register.
- avs_byteenable  in  4  byte-lane write mask.
- avs_read  in  1  read request.
- avs_readdata  out  32  read data, valid when avs_readdatavalid is high.
- avs_readdatavalid  out  1  high exactly one cycle after an accepted read.
- avs_write  in  1  write request.
- avs_writedata  in  32  write data.
- avs_waitrequest  out  1  tied 0; every request is accepted in the cycle it is presented.
- irq  out  1  timer interrupt, level; connects to inr_irq.

Behaviour:
- Register map (word offsets):
  - 0 MTIME_LO
  - 1 MTIME_HI
  - 2 MTIMECMP_LO
  - 3 MTIMECMP_HI
  - 4 CTRL: bit0 EN, bit1 IE
  - 5 STATUS: bit0 MATCH, write-1-to-clear
  - 6 and 7: read 0, writes ignored.
- Reset values:
  - mtime = 0, mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF, CTRL = 0, MATCH = 0, prescaler = 0, hi_shadow = 0.
  - Outputs: avs_readdata = 0, avs_readdatavalid = 0, irq = 0.
- Prescaler:
  - When EN=1, the prescaler counts 0..PRESCALE-1. At the terminal count it wraps to 0 and mtime increments by 1.
  - When EN=0, both the prescaler and mtime hold.
- mtime wraps from 2^64-1 to 0 with no flag.
- Writes:
  - Byte lanes are honoured on every register.
  - A write to MTIME_LO/HI overrides the increment in that cycle and resets the prescaler to 0.
  - A write to the half not being written leaves that half untouched, including any carry into it that cycle.
- Reads (1-cycle latency):
  - avs_readdata and avs_readdatavalid are registered.
  - A read of MTIME_LO returns the current low word and, in the same cycle, latches the current high word into hi_shadow.
  - A read of MTIME_HI returns hi_shadow, so a LO-then-HI sequence is coherent across a carry.
  - avs_readdata holds its last value when no read is issued.
- Simultaneous read and write to the same address: the read returns the pre-write value.
- Compare:
  - match_now = (mtime >= mtimecmp), unsigned 64-bit, evaluated on the registered values.
  - irq is registered: irq <= IE & match_now. It asserts one cycle after the condition becomes true.
  - irq deasserts one cycle after software raises mtimecmp above mtime, or clears IE.
- STATUS.MATCH:
  - Sets on any cycle in which match_now=1, independent of IE.
  - Cleared by writing 1 to bit0.
  - If a set and a clear occur in the same cycle, set wins.
- Reset asserted mid-operation: all state returns to reset values on that edge. A read outstanding at that edge yields no readdatavalid.

Decomposition:
- Package clarvi_timer_pkg holds:
  - enum timer_reg_e for offsets 0..5;
  - packed struct timer_ctrl_t {logic ie; logic en;};
  - localparam MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF.
- Sub-module timer_prescaler (clock, reset, en, clear, tick): isolates the PRESCALE counter and its terminal-count pulse.
- The top level holds the register file, read pipeline and compare logic.

Test Plan:
- Reset, EN=1, PRESCALE=1, run 10 cycles, read MTIME_LO -> readdatavalid one cycle after the read, value 10 ±1 per documented latch timing; irq=0.
- Write MTIME_LO=32'hFFFF_FFFE, MTIME_HI=0, EN=1, wait 4 cycles, read LO then HI -> LO=32'h0000_0001 or later, HI=1; a forced carry between the two reads still yields HI=hi_shadow.
- Write mtimecmp=100, IE=1, EN=1, mtime=0 -> irq rises on the cycle after mtime reaches 100, STATUS=1; write mtimecmp=200 -> irq falls one cycle later; MATCH stays 1 until 1 is written to STATUS.
- PRESCALE=4: EN=1 for 20 cycles -> mtime=5; write EN=0 -> mtime holds at 5 for 10 further cycles.
- Byte-enable write 4'b0010 of 32'hAABBCCDD to MTIMECMP_LO, starting from reset -> reads 32'hFFFF_CCFF.
- Assert reset (reset=0) while irq=1 and a read is outstanding -> next cycle: irq=0, readdatavalid=0, mtime=0, mtimecmp all-ones.
